uart_msg_arbiter: RTL and testbench

- Shares the single outbound UART message path (msg_disasm input) between NUM_SRC independent message producers, e.g. controller replies and unsolicited status reports.
- Each producer presents a complete message with valid/ack.
- The arbiter grants one source at a time in round-robin order, buffers the granted message in a one-deep holding register, and issues it to msg_disasm when the disassembler reports ready.
- Sits between the message producers and msg_disasm.

---
 rtl/uart_msg_arbiter_if.sv | 26 ++
 rtl/uart_msg_arbiter.sv | 99 +++++++++
 tb/tb_uart_msg_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_msg_arbiter_if.sv
// Producer-side and msg_disasm-side signals of the UART message arbiter.
// master: the arbiter drives acks, out_msg/out_req, busy and the counter; slave: the surrounding logic.
interface uart_msg_arbiter_if #(
    parameter int NUM_SRC   = 2,
    parameter int MSG_WIDTH = 32,
    parameter int CNT_WIDTH = 16
);
    logic [NUM_SRC-1:0]           src_valid;
    logic [NUM_SRC*MSG_WIDTH-1:0] src_msg;
    logic [NUM_SRC-1:0]           src_ack;
    logic                         out_ready;
    logic [MSG_WIDTH-1:0]         out_msg;
    logic                         out_req;
    logic                         busy;
    logic [CNT_WIDTH-1:0]         msgs_sent;

    modport master (
        input  src_valid, src_msg, out_ready,
        output src_ack, out_msg, out_req, busy, msgs_sent
    );

    modport slave (
        output src_valid, src_msg, out_ready,
        input  src_ack, out_msg, out_req, busy, msgs_sent
    );
endinterface

// File: rtl/uart_msg_arbiter.sv
// Round-robin arbiter sharing the msg_disasm input among NUM_SRC producers via a one-deep holding register.
// Latency: valid->ack 1 cycle, valid->out_req 2 cycles; out_ready low stalls in ISSUE with out_msg held.
module uart_msg_arbiter #(
    parameter int NUM_SRC   = 2,
    parameter int MSG_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input logic                clk,
    input logic                reset,
    uart_msg_arbiter_if.master bus
);
    localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [GW-1:0]        last_grant;
    logic [GW-1:0]        cand;
    logic [GW-1:0]        grant_idx;
    logic                 grant_vld;
    logic [NUM_SRC-1:0]   ack_nxt;
    logic                 req_nxt;
    logic [NUM_SRC-1:0]   src_ack_q;
    logic                 out_req_q;
    logic [MSG_WIDTH-1:0] out_msg_q;
    logic [CNT_WIDTH-1:0] msgs_sent_q;

    // Search starts just past the previous winner, so simultaneous requesters rotate.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = GW'((int'(last_grant) + k) % NUM_SRC);
            if (!grant_vld && bus.src_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ack_nxt   = '0;
        req_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    ack_nxt[grant_idx] = 1'b1;
                    state_nxt          = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.out_ready) begin
                    req_nxt   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ack_q   <= '0;
            out_req_q   <= 1'b0;
            out_msg_q   <= '0;
            msgs_sent_q <= '0;
            last_grant  <= GW'(NUM_SRC - 1);
        end else begin
            src_ack_q <= ack_nxt;
            out_req_q <= req_nxt;
            if (|ack_nxt) begin
                out_msg_q  <= bus.src_msg[int'(grant_idx) * MSG_WIDTH +: MSG_WIDTH];
                last_grant <= grant_idx;
            end
            // Counter sticks at all-ones rather than wrapping.
            if (req_nxt && (msgs_sent_q != '1)) begin
                msgs_sent_q <= msgs_sent_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.src_ack   = src_ack_q;
    assign bus.out_req   = out_req_q;
    assign bus.out_msg   = out_msg_q;
    assign bus.msgs_sent = msgs_sent_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Randomized and directed bench for uart_msg_arbiter against a transaction-level reference model.
module tb_uart_msg_arbiter;
    localparam int NS  = 3;
    localparam int MW  = 32;
    localparam int CW  = 4;
    localparam int SAT = 15;
    localparam int ML  = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    uart_msg_arbiter_if #(.NUM_SRC(NS), .MSG_WIDTH(MW), .CNT_WIDTH(CW)) bus ();

    uart_msg_arbiter #(.NUM_SRC(NS), .MSG_WIDTH(MW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Source drivers: a list of messages per source, presented in order.
    logic [MW-1:0] src_list [NS][ML];
    int src_len [NS];
    int src_pos [NS];
    int src_gap [NS];
    int deliv   [NS];
    bit rand_gaps;

    // Reference model: pending message, post-issue quiet cycle, round-robin pointer.
    bit            m_pend;
    int            m_cool;
    int            m_last;
    int            m_src;
    int            m_sent;
    logic [MW-1:0] m_msg;
    int            dut_grants [$];
    int            acks;
    int            reqs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit all_done();
        for (int i = 0; i < NS; i++) begin
            if (deliv[i] < src_len[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            bus.src_valid[i] = (src_pos[i] < src_len[i]) && (src_gap[i] == 0);
            bus.src_msg[i*MW +: MW] = (src_pos[i] < src_len[i]) ? src_list[i][src_pos[i]] : MW'($urandom);
        end
    endtask

    task automatic load(input int i, input int n, input logic [31:0] base, input int gap0);
        for (int k = 0; k < n; k++) begin
            src_list[i][k] = (base == 0) ? $urandom : base + k;
        end
        src_len[i] = n;
        src_pos[i] = 0;
        src_gap[i] = gap0;
        deliv[i]   = 0;
    endtask

    task automatic step();
        logic [NS-1:0]    v;
        logic             r;
        logic [NS*MW-1:0] m;
        logic [NS-1:0]    exp_ack;
        logic             exp_req;
        int               g;
        v = bus.src_valid;
        r = bus.out_ready;
        m = bus.src_msg;
        @(posedge clk);
        #1;
        exp_ack = '0;
        exp_req = 1'b0;
        if (m_pend) begin
            if (r) begin
                exp_req = 1'b1;
                m_pend  = 1'b0;
                m_cool  = 1;
                if (m_sent < SAT) m_sent++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (v != '0) begin
            g = -1;
            for (int k = 1; k <= NS; k++) begin
                if (g < 0 && v[(m_last + k) % NS]) g = (m_last + k) % NS;
            end
            exp_ack[g] = 1'b1;
            m_msg      = m[g*MW +: MW];
            m_last     = g;
            m_src      = g;
            m_pend     = 1'b1;
        end
        chk("ack", bus.src_ack, exp_ack);
        chk("req", bus.out_req, exp_req);
        chk("msg", bus.out_msg, m_msg);
        chk("busy", bus.busy, (m_pend || m_cool > 0));
        chk("sent", bus.msgs_sent, m_sent);
        if (exp_req) begin
            if (deliv[m_src] < src_len[m_src]) begin
                chk("order", bus.out_msg, src_list[m_src][deliv[m_src]]);
                deliv[m_src]++;
            end else begin
                chk("extra_delivery", deliv[m_src], src_len[m_src] - 1);
            end
        end
        // Sources react to the ack they actually see.
        for (int i = 0; i < NS; i++) begin
            if (bus.src_ack[i]) begin
                dut_grants.push_back(i);
                src_pos[i]++;
                src_gap[i] = rand_gaps ? int'($urandom_range(0, 3)) : 0;
            end else if (src_gap[i] > 0) begin
                src_gap[i]--;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        for (int i = 0; i < NS; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
            src_gap[i] = 0;
            deliv[i]   = 0;
        end
        drive();
        reset = 1'b1;
        #1;
        chk("rst_ack", bus.src_ack, 0);
        chk("rst_req", bus.out_req, 0);
        chk("rst_msg", bus.out_msg, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sent", bus.msgs_sent, 0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        m_pend = 1'b0;
        m_cool = 0;
        m_last = NS - 1;
        m_src  = 0;
        m_msg  = '0;
        m_sent = 0;
        dut_grants.delete();
    endtask

    task automatic run_until_done(input int budget, input string tag);
        int c;
        c = 0;
        while (!all_done() && c < budget) begin
            step();
            c++;
        end
        chk({tag, "_timeout"}, all_done(), 1);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        rand_gaps     = 1'b0;
        #2;
        do_reset();

        // Single request
        load(0, 1, 32'hDEADBEEF, 0);
        drive();
        step();
        chk("single_ack", bus.src_ack, 3'b001);
        step();
        chk("single_req", bus.out_req, 1);
        chk("single_msg", bus.out_msg, 32'hDEADBEEF);
        step();
        step();
        chk("single_sent", bus.msgs_sent, 1);
        chk("single_idle", bus.busy, 0);

        // Contention between two sources asserting together
        do_reset();
        load(0, 4, 32'h11111111, 0);
        load(1, 4, 32'h22222222, 0);
        drive();
        run_until_done(100, "cont");
        chk("cont_sent", bus.msgs_sent, 8);
        chk("cont_grants", dut_grants.size(), 8);
        if (dut_grants.size() >= 8) begin
            for (int k = 0; k < 8; k++) chk("cont_rr", dut_grants[k], k % 2);
        end

        // Backpressure
        do_reset();
        bus.out_ready = 1'b0;
        load(0, 1, 32'hCAFEF00D, 0);
        drive();
        acks = 0;
        reqs = 0;
        repeat (51) begin
            step();
            acks += int'(bus.src_ack != '0);
            reqs += int'(bus.out_req);
        end
        chk("bp_acks", acks, 1);
        chk("bp_reqs", reqs, 0);
        chk("bp_busy", bus.busy, 1);
        chk("bp_msg", bus.out_msg, 32'hCAFEF00D);
        bus.out_ready = 1'b1;
        step();
        chk("bp_release", bus.out_req, 1);
        step();
        chk("bp_one_pulse", bus.out_req, 0);

        // Late source: src0 rises while src1's message sits in ISSUE
        do_reset();
        load(1, 3, 32'hB0000000, 0);
        load(0, 1, 32'hA0000000, 1);
        drive();
        run_until_done(100, "late");
        chk("late_grants", dut_grants.size(), 4);
        if (dut_grants.size() >= 4) begin
            chk("late_g0", dut_grants[0], 1);
            chk("late_g1", dut_grants[1], 0);
            chk("late_g2", dut_grants[2], 1);
            chk("late_g3", dut_grants[3], 1);
        end

        // Async reset while stalled in ISSUE, then silence
        do_reset();
        bus.out_ready = 1'b0;
        load(0, 1, 32'h12345678, 0);
        drive();
        step();
        step();
        step();
        chk("pre_rst_busy", bus.busy, 1);
        do_reset();
        bus.out_ready = 1'b1;
        reqs = 0;
        repeat (20) begin
            step();
            reqs += int'(bus.out_req);
        end
        chk("post_rst_noreq", reqs, 0);

        // Counter saturation
        do_reset();
        load(0, 20, 32'h5A000000, 0);
        drive();
        run_until_done(200, "sat");
        chk("sat_sent", bus.msgs_sent, 15);

        // Randomized traffic and readiness
        do_reset();
        rand_gaps = 1'b1;
        for (int i = 0; i < NS; i++) load(i, 12, 32'h0, int'($urandom_range(0, 3)));
        drive();
        begin
            int c;
            c = 0;
            while (!all_done() && c < 3000) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                step();
                c++;
            end
        end
        chk("rand_timeout", all_done(), 1);
        rand_gaps = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
